// File: rtl/hb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hb_pkg
//  Description : Shared types and constants for the heartbeat mode scheduler
//                (FSM state encoding, mode indices, hold counter width).
//  Revision    : 1.0  initial release
// ============================================================================
package hb_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } hb_state_t;

    localparam logic [1:0] MODE_IDLE = 2'd0;
    localparam logic [1:0] MODE_BUSY = 2'd1;
    localparam logic [1:0] MODE_WARN = 2'd2;
    localparam logic [1:0] MODE_ERR  = 2'd3;

    localparam int HOLD_W = 4;

endpackage
`default_nettype wire

// File: rtl/hb_prio_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : hb_prio_encoder
//  Description : Combinational 4-to-2 priority encoder; the highest set
//                request bit wins, no request selects the idle mode.
//  Revision    : 1.0  initial release
// ============================================================================
module hb_prio_encoder
    import hb_pkg::*;
(
    input  logic [3:0] req,
    output logic [1:0] winner
);

    // Highest-index active request wins
    always_comb begin
        winner = MODE_IDLE;
        if (req[3]) begin
            winner = MODE_ERR;
        end else if (req[2]) begin
            winner = MODE_WARN;
        end else if (req[1]) begin
            winner = MODE_BUSY;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hb_mode_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : hb_mode_scheduler
//  Description : Arbitrates the shared heartbeat divider between four status
//                modes, programs it over a valid/ready config handshake and
//                gates its enable so pattern changes land on period edges.
//  Revision    : 1.0  initial release
// ============================================================================
module hb_mode_scheduler
    import hb_pkg::*;
#(
    parameter int              CNT_W    = 32,
    parameter longint unsigned THR0     = 100_000,
    parameter longint unsigned ON0      = 10_000,
    parameter longint unsigned THR1     = 50_000,
    parameter longint unsigned ON1      = 20_000,
    parameter longint unsigned THR2     = 20_000,
    parameter longint unsigned ON2      = 10_000,
    parameter longint unsigned THR3     = 10_000,
    parameter longint unsigned ON3      = 5_000,
    parameter int              MIN_HOLD = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [3:0]       req,
    input  logic             period_done,
    input  logic             cfg_ready,
    output logic             cfg_valid,
    output logic [CNT_W-1:0] cfg_threshold,
    output logic [CNT_W-1:0] cfg_on_time,
    output logic             div_enable,
    output logic [1:0]       active_mode,
    output logic             mode_change
);

    // Only the thresholds need a fit check: every on-time is below its threshold.
    localparam bit C_FIT_OK = (CNT_W >= 64) ||
                              (((THR0 >> CNT_W) == 0) && ((THR1 >> CNT_W) == 0) &&
                               ((THR2 >> CNT_W) == 0) && ((THR3 >> CNT_W) == 0));
    localparam bit C_MODE_OK = (THR0 >= 2) && (ON0 > 0) && (ON0 < THR0) &&
                               (THR1 >= 2) && (ON1 > 0) && (ON1 < THR1) &&
                               (THR2 >= 2) && (ON2 > 0) && (ON2 < THR2) &&
                               (THR3 >= 2) && (ON3 > 0) && (ON3 < THR3);
    localparam bit C_HOLD_OK = (MIN_HOLD >= 1) && (MIN_HOLD <= 15);

    generate
        if (!(C_FIT_OK && C_MODE_OK && C_HOLD_OK)) begin : g_bad_cfg
            $error("hb_mode_scheduler: illegal threshold/on-time/MIN_HOLD parameters");
        end
    endgenerate

    hb_state_t             r_state;
    hb_state_t             w_state_nxt;
    logic [1:0]            w_winner;
    logic [1:0]            r_target;
    logic [1:0]            r_active_mode;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic [HOLD_W-1:0]     w_hold_inc;
    logic                  r_mode_change;
    logic                  w_load;
    logic                  w_accept;
    logic                  w_period_tick;
    logic [CNT_W-1:0]      r_cfg_threshold;
    logic [CNT_W-1:0]      r_cfg_on_time;
    logic [CNT_W-1:0]      w_thr_sel;
    logic [CNT_W-1:0]      w_on_sel;

    hb_prio_encoder u_prio (
        .req    (req),
        .winner (w_winner)
    );

    // Completed-period count after this boundary, saturated at MIN_HOLD
    assign w_hold_inc    = (r_hold_cnt >= HOLD_W'(MIN_HOLD)) ? HOLD_W'(MIN_HOLD)
                                                             : r_hold_cnt + 1'b1;
    assign w_period_tick = (r_state == ST_RUN) && enable && period_done;

    // Period / on-time words for the current winner
    always_comb begin
        w_thr_sel = CNT_W'(THR0);
        w_on_sel  = CNT_W'(ON0);
        case (w_winner)
            MODE_BUSY: begin w_thr_sel = CNT_W'(THR1); w_on_sel = CNT_W'(ON1); end
            MODE_WARN: begin w_thr_sel = CNT_W'(THR2); w_on_sel = CNT_W'(ON2); end
            MODE_ERR:  begin w_thr_sel = CNT_W'(THR3); w_on_sel = CNT_W'(ON3); end
            default:   begin w_thr_sel = CNT_W'(THR0); w_on_sel = CNT_W'(ON0); end
        endcase
    end

    // Next-state logic; enable low always wins and returns to OFF
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_OFF: begin
                if (enable) begin
                    w_state_nxt = ST_LOAD;
                    w_load      = 1'b1;
                end
            end
            ST_LOAD: begin
                if (!enable) begin
                    w_state_nxt = ST_OFF;
                end else if (cfg_ready) begin
                    w_state_nxt = ST_RUN;
                    w_accept    = 1'b1;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    w_state_nxt = ST_OFF;
                end else if (period_done) begin
                    if ((w_winner > r_active_mode) ||
                        ((w_winner < r_active_mode) && (w_hold_inc >= HOLD_W'(MIN_HOLD)))) begin
                        w_state_nxt = ST_LOAD;
                        w_load      = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_OFF;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latched target/config, active mode, hold counter and change pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_target        <= MODE_IDLE;
            r_active_mode   <= MODE_IDLE;
            r_hold_cnt      <= '0;
            r_mode_change   <= 1'b0;
            r_cfg_threshold <= '0;
            r_cfg_on_time   <= '0;
        end else begin
            r_mode_change <= w_accept;
            if (w_load) begin
                r_target        <= w_winner;
                r_cfg_threshold <= w_thr_sel;
                r_cfg_on_time   <= w_on_sel;
            end
            if (w_accept) begin
                r_active_mode <= r_target;
                r_hold_cnt    <= '0;
            end else if (w_period_tick) begin
                r_hold_cnt <= w_hold_inc;
            end
        end
    end

    assign cfg_valid     = (r_state == ST_LOAD);
    assign div_enable    = (r_state == ST_RUN);
    assign cfg_threshold = r_cfg_threshold;
    assign cfg_on_time   = r_cfg_on_time;
    assign active_mode   = r_active_mode;
    assign mode_change   = r_mode_change;

endmodule
`default_nettype wire

// File: tb/tb_hb_mode_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hb_mode_scheduler
//  Description : Self-checking bench for hb_mode_scheduler with a
//                behavioural reference model and directed scenarios.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hb_mode_scheduler;

    localparam int CNT_W    = 32;
    localparam int MIN_HOLD = 2;
    localparam int TH_TAB [4] = '{100, 50, 20, 10};
    localparam int ON_TAB [4] = '{10, 20, 10, 5};

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b0;
    logic [3:0]       req = 4'd0;
    logic             period_done = 1'b0;
    logic             cfg_ready = 1'b0;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_threshold;
    logic [CNT_W-1:0] cfg_on_time;
    logic             div_enable;
    logic [1:0]       active_mode;
    logic             mode_change;

    int checks = 0;
    int failures = 0;

    hb_mode_scheduler #(
        .CNT_W(CNT_W),
        .THR0(100), .ON0(10),
        .THR1(50),  .ON1(20),
        .THR2(20),  .ON2(10),
        .THR3(10),  .ON3(5),
        .MIN_HOLD(MIN_HOLD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .req           (req),
        .period_done   (period_done),
        .cfg_ready     (cfg_ready),
        .cfg_valid     (cfg_valid),
        .cfg_threshold (cfg_threshold),
        .cfg_on_time   (cfg_on_time),
        .div_enable    (div_enable),
        .active_mode   (active_mode),
        .mode_change   (mode_change)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0=off, 1=offering config, 2=divider running
    int m_phase = 0;
    int m_target = 0;
    int m_active = 0;
    int m_periods = 0;
    int m_thr = 0;
    int m_on = 0;
    int m_mc = 0;

    function automatic int top_request(input logic [3:0] r);
        int w = 0;
        for (int i = 0; i < 4; i++) if (r[i]) w = i;
        return w;
    endfunction

    task automatic m_offer(input int mode);
        m_phase  = 1;
        m_target = mode;
        m_thr    = TH_TAB[mode];
        m_on     = ON_TAB[mode];
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = 0; m_target = 0; m_active = 0; m_periods = 0;
            m_thr = 0; m_on = 0; m_mc = 0;
        end else begin
            m_mc = 0;
            if (!enable) begin
                m_phase = 0;
            end else if (m_phase == 0) begin
                m_offer(top_request(req));
            end else if (m_phase == 1) begin
                if (cfg_ready) begin
                    m_phase = 2; m_active = m_target; m_periods = 0; m_mc = 1;
                end
            end else if (period_done) begin
                int w;
                w = top_request(req);
                m_periods = (m_periods + 1 > MIN_HOLD) ? MIN_HOLD : m_periods + 1;
                if (w > m_active || (w < m_active && m_periods >= MIN_HOLD)) m_offer(w);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("cyc_cfg_valid", cfg_valid, (m_phase == 1) ? 1 : 0);
        chk("cyc_div_enable", div_enable, (m_phase == 2) ? 1 : 0);
        chk("cyc_threshold", cfg_threshold, m_thr);
        chk("cyc_on_time", cfg_on_time, m_on);
        chk("cyc_active_mode", active_mode, m_active);
        chk("cyc_mode_change", mode_change, m_mc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset, then power-up load of idle mode
        enable = 1'b1; req = 4'b0000; cfg_ready = 1'b1; reset = 1'b0;
        tick();
        chk("rst_valid", cfg_valid, 0);
        chk("rst_div", div_enable, 0);
        chk("rst_active", active_mode, 0);
        chk("rst_thr", cfg_threshold, 0);
        tick(); tick();
        reset = 1'b1;
        tick();
        chk("t1_valid", cfg_valid, 1);
        chk("t1_thr", cfg_threshold, 100);
        chk("t1_on", cfg_on_time, 10);
        chk("t1_div_off", div_enable, 0);
        tick();
        chk("t1_div", div_enable, 1);
        chk("t1_active", active_mode, 0);
        chk("t1_mc", mode_change, 1);
        tick();
        chk("t1_mc_single", mode_change, 0);

        // 2: error request mid-period waits for the boundary, then preempts
        req = 4'b1000;
        tick(); tick(); tick();
        chk("t2_no_early", cfg_valid, 0);
        chk("t2_still_run", div_enable, 1);
        period_done = 1'b1;
        tick();
        period_done = 1'b0;
        chk("t2_div", div_enable, 0);
        chk("t2_valid", cfg_valid, 1);
        chk("t2_thr", cfg_threshold, 10);
        chk("t2_on", cfg_on_time, 5);
        tick();
        chk("t2_active", active_mode, 3);

        // 3: downgrade to busy needs MIN_HOLD completed periods
        req = 4'b0010;
        tick();
        period_done = 1'b1;
        tick();
        period_done = 1'b0;
        chk("t3_stay_div", div_enable, 1);
        chk("t3_stay_valid", cfg_valid, 0);
        tick(); tick();
        cfg_ready = 1'b0;
        period_done = 1'b1;
        tick();
        period_done = 1'b0;
        chk("t3_valid", cfg_valid, 1);
        chk("t3_thr", cfg_threshold, 50);
        chk("t3_on", cfg_on_time, 20);

        // 4: offer held stable under backpressure; stray period_done ignored
        for (int i = 0; i < 5; i++) begin
            period_done = (i == 2);
            tick();
            chk("t4_valid", cfg_valid, 1);
            chk("t4_thr", cfg_threshold, 50);
            chk("t4_on", cfg_on_time, 20);
            chk("t4_div", div_enable, 0);
        end
        period_done = 1'b0;
        cfg_ready = 1'b1;
        tick();
        chk("t4_active", active_mode, 1);
        chk("t4_mc", mode_change, 1);
        chk("t4_div_on", div_enable, 1);

        // 5: enable drop beats a simultaneous preempting period_done
        req = 4'b1000;
        enable = 1'b0;
        period_done = 1'b1;
        tick();
        period_done = 1'b0;
        chk("t5_valid", cfg_valid, 0);
        chk("t5_div", div_enable, 0);
        chk("t5_active", active_mode, 1);
        tick();
        chk("t5_no_load", cfg_valid, 0);
        // re-enable reloads even when the winner matches the active mode
        req = 4'b0010;
        cfg_ready = 1'b0;
        enable = 1'b1;
        tick();
        chk("t5_reload_valid", cfg_valid, 1);
        chk("t5_reload_thr", cfg_threshold, 50);

        // 6: asynchronous reset while offering
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("t6_valid", cfg_valid, 0);
        chk("t6_div", div_enable, 0);
        chk("t6_mc", mode_change, 0);
        chk("t6_active", active_mode, 0);
        tick();
        reset = 1'b1;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
